// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss/fill path: FSM encodings, field widths
// and the block-relative word address helper.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fill_state_e;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int TAG_W           = 9;
  localparam int OFFSET_W        = 4;
  localparam int WORD_IDX_W      = 3;
  localparam int TAG_MSB         = 15;
  localparam int TAG_LSB         = 7;

  // Byte address of 16-bit word idx inside the block at base (base is block aligned).
  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [WORD_IDX_W-1:0] idx);
    return {base[15:OFFSET_W], idx, 1'b0};
  endfunction

endpackage

// File: rtl/cnt_3bit_wen.sv
// 3-bit up counter built from dff cells: increment enable, synchronous clear
// (wins over enable) and a wrap flag that is high while incrementing from 7.
module cnt_3bit_wen
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_IDX_W-1:0] cnt,
  output logic                  wrap
);

  logic [WORD_IDX_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt + 3'd1;
  end

  assign wrap = en & ~clr & (cnt == 3'd7);

  for (genvar i = 0; i < WORD_IDX_W; i++) begin : g_bit
    dff u_dff (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cnt_d[i]),
      .q     (cnt[i])
    );
  end

endmodule

// File: rtl/dff.sv
// Single-bit D flip-flop with asynchronous active-low reset to 0.
module dff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches an 8-word block, steers returned words
// into the data array and pulses the tag write. CACHE_FILL_CRITICAL_WORD_FIRST_EN
// starts the fetch at the missed word instead of word 0.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  word_offset,
  output logic        write_tag_array,
  output logic [8:0]  tag_out,
  output logic [1:0]  fsm_state
);

  fill_state_e           state_q, state_d;
  logic [15:0]           base_q, base_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [WORD_IDX_W-1:0] start_q, start_d;
  logic                  iss_done_q, iss_done_d;
  logic                  rcv_done_q, rcv_done_d;

  logic                  iss_clr, iss_en, iss_wrap;
  logic                  rcv_clr, rcv_en, rcv_wrap;
  logic [WORD_IDX_W-1:0] iss_cnt, rcv_cnt;
  logic [WORD_IDX_W-1:0] miss_start;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign miss_start = miss_address[OFFSET_W-1:1];
`else
  assign miss_start = '0;
`endif

  cnt_3bit_wen u_iss_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (iss_clr),
    .en    (iss_en),
    .cnt   (iss_cnt),
    .wrap  (iss_wrap)
  );

  cnt_3bit_wen u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (rcv_clr),
    .en    (rcv_en),
    .cnt   (rcv_cnt),
    .wrap  (rcv_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      tag_q      <= '0;
      start_q    <= '0;
      iss_done_q <= 1'b0;
      rcv_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      tag_q      <= tag_d;
      start_q    <= start_d;
      iss_done_q <= iss_done_d;
      rcv_done_q <= rcv_done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    tag_d            = tag_q;
    start_d          = start_q;
    iss_done_d       = iss_done_q;
    rcv_done_d       = rcv_done_q;
    iss_clr          = 1'b0;
    iss_en           = 1'b0;
    rcv_clr          = 1'b0;
    rcv_en           = 1'b0;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_offset      = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset is folded in so the stall drops the instant reset asserts.
        fsm_busy = miss_detected & rst;
        if (miss_detected) begin
          base_d     = {miss_address[15:OFFSET_W], {OFFSET_W{1'b0}}};
          tag_d      = miss_address[TAG_MSB:TAG_LSB];
          start_d    = miss_start;
          iss_clr    = 1'b1;
          rcv_clr    = 1'b1;
          iss_done_d = 1'b0;
          rcv_done_d = 1'b0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        fsm_busy = 1'b1;
        if (!iss_done_q) begin
          memory_read    = 1'b1;
          memory_address = word_addr(base_q, start_q + iss_cnt);
          iss_en         = 1'b1;
          if (iss_wrap) iss_done_d = 1'b1;
        end
        // Returns are counted independently of issues; only the count matters.
        if (memory_data_valid && !rcv_done_q) begin
          write_data_array = 1'b1;
          word_offset      = start_q + rcv_cnt;
          rcv_en           = 1'b1;
          if (rcv_wrap) begin
            rcv_done_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tag_out   = tag_q;
  assign fsm_state = state_q;

endmodule
